// File: rtl/bit_pos_streamer_if.sv
// Handshake and job bus between a requester and bit_pos_streamer.
// The requester uses the master modport; the streamer uses the slave modport.
interface bit_pos_streamer_if;
    logic        start;
    logic [31:0] data;
    logic        order;
    logic        busy;
    logic        pos_valid;
    logic        pos_ready;
    logic [5:0]  pos;
    logic        done;
    logic [5:0]  count;

    modport master (
        output start, data, order, pos_ready,
        input  busy, pos_valid, pos, done, count
    );

    modport slave (
        input  start, data, order, pos_ready,
        output busy, pos_valid, pos, done, count
    );
endinterface

// File: rtl/bit_pos_streamer.sv
// Captures a 32-bit word and streams the index of each set bit, then pulses done with the count.
// Optional abort input is enabled by defining BIT_POS_STREAMER_ABORT_EN.
module bit_pos_streamer #(
    parameter bit ORDER_DEFAULT = 1'b0
) (
    input  logic               clk,
    input  logic               reset,
`ifdef BIT_POS_STREAMER_ABORT_EN
    input  logic               abort,
`endif
    bit_pos_streamer_if.slave  bus
);

    typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

    state_e      state_q, state_d;
    logic [31:0] shadow_q, shadow_d;
    logic        ord_q, ord_d;
    logic [5:0]  count_q, count_d;

    logic [4:0]  cur_idx;
    logic [31:0] shadow_clr;
    logic        busy, pos_valid, done;
    logic [5:0]  pos;

    // Last assignment wins: upward scan keeps the highest set bit, downward keeps the lowest.
    function automatic logic [4:0] find_idx(input logic [31:0] v, input logic msb_first);
        logic [4:0] idx;
        idx = '0;
        if (msb_first) begin
            for (int i = 0; i < 32; i++) begin
                if (v[i]) idx = 5'(i);
            end
        end else begin
            for (int i = 31; i >= 0; i--) begin
                if (v[i]) idx = 5'(i);
            end
        end
        return idx;
    endfunction

    assign cur_idx    = find_idx(shadow_q, ord_q);
    assign shadow_clr = shadow_q & ~(32'd1 << cur_idx);

    always_comb begin
        state_d   = state_q;
        shadow_d  = shadow_q;
        ord_d     = ord_q;
        count_d   = count_q;
        busy      = 1'b0;
        pos_valid = 1'b0;
        done      = 1'b0;
        pos       = 6'd0;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    shadow_d = bus.data;
                    ord_d    = bus.order;
                    count_d  = 6'd0;
                    state_d  = (bus.data == 32'd0) ? StDone : StScan;
                end
            end
            StScan: begin
                busy      = 1'b1;
                pos_valid = 1'b1;
                pos       = {1'b0, cur_idx};
                if (bus.pos_ready) begin
                    shadow_d = shadow_clr;
                    count_d  = count_q + 6'd1;
                    if (shadow_clr == 32'd0) state_d = StDone;
                end
            end
            StDone: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

`ifdef BIT_POS_STREAMER_ABORT_EN
        // A same-cycle handshake has already updated count_d and is kept.
        if (abort && (state_q != StIdle)) state_d = StIdle;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            shadow_q <= 32'd0;
            ord_q    <= ORDER_DEFAULT;
            count_q  <= 6'd0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            ord_q    <= ord_d;
            count_q  <= count_d;
        end
    end

    assign bus.busy      = busy;
    assign bus.pos_valid = pos_valid;
    assign bus.pos       = pos;
    assign bus.done      = done;
    assign bus.count     = count_q;

endmodule

// File: tb/tb_bit_pos_streamer.sv
// Self-checking bench for bit_pos_streamer: directed jobs plus randomized words and backpressure.
// Covers the abort path when BIT_POS_STREAMER_ABORT_EN is defined.
module tb_bit_pos_streamer;

    logic clk;
    logic reset;
`ifdef BIT_POS_STREAMER_ABORT_EN
    logic abort;
`endif
    int checks;
    int failures;

    bit_pos_streamer_if bus ();

    bit_pos_streamer #(
        .ORDER_DEFAULT (1'b0)
    ) dut (
        .clk   (clk),
`ifdef BIT_POS_STREAMER_ABORT_EN
        .abort (abort),
`endif
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag, input logic [5:0] exp_count);
        chk({tag, ".busy"}, 32'(bus.busy), 32'd0);
        chk({tag, ".pos_valid"}, 32'(bus.pos_valid), 32'd0);
        chk({tag, ".pos"}, 32'(bus.pos), 32'd0);
        chk({tag, ".done"}, 32'(bus.done), 32'd0);
        chk({tag, ".count"}, 32'(bus.count), 32'(exp_count));
    endtask

    // Called at a negedge while the DUT is idle; returns at the negedge of the cycle after done.
    task automatic run_job(input logic [31:0] d, input logic o, input int ready_pct,
                           input int stall, input bit noisy);
        int   q[$];
        int   emitted;
        int   cycles;
        int   exp_count;
        logic rdy;
        for (int i = 0; i < 32; i++) begin
            if (d[i]) begin
                if (o) q.push_front(i);
                else   q.push_back(i);
            end
        end
        exp_count = q.size();
        chk("job.pre.busy", 32'(bus.busy), 32'd0);
        bus.start = 1'b1;
        bus.data  = d;
        bus.order = o;
        @(negedge clk);
        bus.start = 1'b0;
        emitted   = 0;
        cycles    = 0;
        while (q.size() > 0 && cycles < 200) begin
            chk("scan.pos_valid", 32'(bus.pos_valid), 32'd1);
            chk("scan.busy", 32'(bus.busy), 32'd1);
            chk("scan.done", 32'(bus.done), 32'd0);
            chk("scan.pos", 32'(bus.pos), 32'(q[0]));
            chk("scan.count", 32'(bus.count), 32'(emitted));
            rdy = (cycles >= stall) && ($urandom_range(99) < ready_pct);
            bus.pos_ready = rdy;
            if (noisy) begin
                bus.start = 1'($urandom);
                bus.data  = $urandom;
                bus.order = 1'($urandom);
            end
            if (rdy) begin
                void'(q.pop_front());
                emitted++;
            end
            @(negedge clk);
            cycles++;
        end
        if (cycles >= 200) chk("scan.timeout", 32'(cycles), 32'd0);
        bus.start     = 1'b0;
        bus.pos_ready = 1'b0;
        chk("done.done", 32'(bus.done), 32'd1);
        chk("done.busy", 32'(bus.busy), 32'd1);
        chk("done.pos_valid", 32'(bus.pos_valid), 32'd0);
        chk("done.count", 32'(bus.count), 32'(exp_count));
        @(negedge clk);
        chk_idle("post", 6'(exp_count));
    endtask

    initial begin
        logic [31:0] rd;
        checks         = 0;
        failures       = 0;
        reset          = 1'b1;
        bus.start      = 1'b0;
        bus.data       = 32'd0;
        bus.order      = 1'b0;
        bus.pos_ready  = 1'b0;
`ifdef BIT_POS_STREAMER_ABORT_EN
        abort          = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk_idle("reset", 6'd0);
        reset = 1'b0;

        run_job(32'h0fff0010, 1'b0, 100, 0, 1'b0);
        run_job(32'h0fff0010, 1'b1, 100, 0, 1'b0);
        run_job(32'h00000000, 1'b0, 100, 0, 1'b0);
        run_job(32'hffffffff, 1'b0, 100, 0, 1'b0);
        run_job(32'h80000001, 1'b0, 100, 3, 1'b1);

        // Reset in cycle 3 of a job.
        bus.start = 1'b1;
        bus.data  = 32'h0fff0010;
        bus.order = 1'b0;
        @(negedge clk);
        bus.start     = 1'b0;
        bus.pos_ready = 1'b1;
        chk("rst.c1.pos", 32'(bus.pos), 32'd4);
        @(negedge clk);
        chk("rst.c2.pos", 32'(bus.pos), 32'd16);
        @(negedge clk);
        chk("rst.c3.pos", 32'(bus.pos), 32'd17);
        reset = 1'b1;
        @(negedge clk);
        reset         = 1'b0;
        bus.pos_ready = 1'b0;
        chk_idle("rst.c4", 6'd0);
        @(negedge clk);
        chk_idle("rst.c5", 6'd0);
        run_job(32'h0fff0010, 1'b0, 100, 0, 1'b0);

`ifdef BIT_POS_STREAMER_ABORT_EN
        // Abort in cycle 3 with a same-cycle handshake.
        bus.start = 1'b1;
        bus.data  = 32'h0fff0010;
        bus.order = 1'b0;
        @(negedge clk);
        bus.start     = 1'b0;
        bus.pos_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("abort.c3.pos", 32'(bus.pos), 32'd17);
        abort = 1'b1;
        @(negedge clk);
        abort         = 1'b0;
        bus.pos_ready = 1'b0;
        chk_idle("abort.c4", 6'd3);
        @(negedge clk);
        chk_idle("abort.c5", 6'd3);
        run_job(32'h00000005, 1'b1, 100, 0, 1'b0);
`endif

        for (int n = 0; n < 24; n++) begin
            case ($urandom_range(3))
                0:       rd = $urandom;
                1:       rd = $urandom & $urandom & $urandom;
                2:       rd = 32'd1 << $urandom_range(31);
                default: rd = ($urandom_range(1) == 0) ? 32'd0 : 32'hffffffff;
            endcase
            run_job(rd, 1'($urandom), 60, int'($urandom_range(2)), 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bit_pos_streamer.md
# bit_pos_streamer

Multi-cycle bit-position extractor that sits directly downstream of the bit-finder stage in the p4 datapath experiments. It captures one 32-bit word on `start`, then emits the 6-bit index of every set bit, one index per accepted handshake, in LSB-first or MSB-first order. When the word is exhausted it pulses `done` with the total set-bit count. Internally it repeatedly locates the first set bit and clears it.

## Interface
- `ORDER_DEFAULT`, default 0: ordering used at reset; 0 = LSB-first, 1 = MSB-first (overridden per job by `order`)
- `clk`  input  1  single system clock, all state updates on rising edge
- `reset`  input  1  synchronous, active-high reset
- `start`  input  1  job request; sampled only in IDLE
- `data`  input  32  word to scan; captured on accepted `start`
- `order`  input  1  captured with `data`; 0 = lowest index first, 1 = highest index first
- `busy`  output  1  high in SCAN and DONE
- `pos_valid`  output  1  `pos` holds a valid bit index
- `pos_ready`  input  1  consumer accepts `pos` when high together with `pos_valid`
- `pos`  output  6  bit index 0..31 of the current set bit; upper bit always 0
- `done`  output  1  one-cycle pulse at end of job
- `count`  output  6  number of indices emitted in the last job (0..32); held until next accepted `start`
- `abort`  input  1  present only with `BIT_POS_STREAMER_ABORT_EN`

## Operation
- Registers: `shadow[31:0]`, `ord`, `count[5:0]`, state ∈ {IDLE, SCAN, DONE}.
- IDLE: `busy`=0, `pos_valid`=0. On `start`=1: `shadow`←`data`, `ord`←`order`, `count`←0. If `data`==0, next = DONE; else next = SCAN.
- SCAN: `pos_valid`=1. `pos` is combinational from `shadow`: lowest set index if `ord`=0, highest if `ord`=1. On `pos_valid && pos_ready`: clear `shadow[pos]`, `count`←`count`+1. If the cleared bit was the last set bit, next = DONE; else stay in SCAN.
- No handshake (`pos_ready`=0): `shadow`, `pos`, and `count` hold. `pos` must stay stable while `pos_valid`=1 and the handshake has not yet occurred.
- DONE: `done`=1, `pos_valid`=0, `busy`=1 for exactly one cycle; next = IDLE.
- `start` in SCAN or DONE is ignored: no effect and no queueing.
- `count` is 6 bits so that 32 is representable. No wrap occurs.
- Changes on `data` or `order` outside a start-accept edge have no effect.

## Timing
- Reset values: state IDLE, `shadow`=0, `ord`=`ORDER_DEFAULT`, `count`=0, `busy`=0, `pos_valid`=0, `pos`=0, `done`=0.
- Reset wins over every other input in the same cycle. A reset during SCAN or DONE returns to IDLE on that edge with no `done` pulse.
- `start` is accepted at edge 0. The first `pos_valid` appears in cycle 1.
- With `pos_ready` held at 1 and k set bits, indices occupy cycles 1..k and `done` pulses in cycle k+1. For `data`==0, `done` pulses in cycle 1 with `count`=0.
- Throughput is one index per cycle. Each cycle of backpressure adds exactly one cycle of latency.
- The next `start` can be accepted in the cycle after `done` (IDLE).

## Configuration
- `BIT_POS_STREAMER_ABORT_EN` defined: the `abort` input port exists.
  - `abort`=1 in SCAN or DONE forces IDLE on the next edge, with no `done` pulse and `count` frozen at the indices emitted so far.
  - A handshake in the same cycle as `abort` is still counted.
  - `abort` in IDLE is ignored and has priority below `reset`.
- Macro not defined: no `abort` port; jobs always run to completion.

## Test plan
- `data`=32'h0fff0010, `order`=0, `pos_ready`=1 → `pos` sequence 4,16,17,…,27 in cycles 1–13; `done` in cycle 14; `count`=13.
- Same word with `order`=1 → 27,26,…,16,4; `count`=13.
- `data`=0 → no `pos_valid`; `done` in cycle 1; `count`=0. `data`=32'hFFFFFFFF with `order`=0 → indices 0..31; `count`=6'd32.
- Backpressure: `data`=32'h80000001, `pos_ready` low for cycles 1–3 → `pos`=0 held stable; accepted in cycle 4; `pos`=31 in cycle 5; `done` in cycle 6. A `start` asserted mid-job is ignored.
- Reset in cycle 3 of a 32'h0fff0010 job → IDLE next cycle, all outputs at reset values, no `done`; a new job then runs normally.
- With `BIT_POS_STREAMER_ABORT_EN`: `abort` in cycle 3 of the 32'h0fff0010 job with `pos_ready`=1 → IDLE in cycle 4, `count`=3, no `done`.
